// File: rtl/mips_pkg.sv
// Shared fetch-side definitions: machine width, reset PC, fetch FSM states
// and the {pc, inst} entry carried from the fetch unit toward decode.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_buf.sv
// Two-entry FIFO of fetch entries; flush empties it and wins over push/pop.
// The head reads as zero whenever the FIFO is empty.
module fetch_buf
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t entries [2];
    logic         rd_ptr;
    logic         wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            entries[wr_ptr] <= push_entry;
        end
    end

    assign head = (count != 2'd0) ? entries[rd_ptr] : '0;

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, keeps one request outstanding to
// instruction memory and queues returned words toward decode.
module ifu
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    fetch_state_e    state;
    fetch_state_e    next_state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            rst_q;
    logic            accept;
    logic            push;
    logic            pop;
    logic [1:0]      count;
    fetch_entry_t    head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A redirect while a request is in flight turns its response into a discard.
    always_comb begin
        next_state = state;
        unique case (state)
            FETCH_IDLE: begin
                if (accept) begin
                    next_state = redirect ? FETCH_DROP : FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (imem_resp_valid) begin
                    next_state = FETCH_IDLE;
                end else if (redirect) begin
                    next_state = FETCH_DROP;
                end
            end
            FETCH_DROP: begin
                if (imem_resp_valid) begin
                    next_state = FETCH_IDLE;
                end
            end
            default: next_state = FETCH_IDLE;
        endcase
    end

    // Requests stay quiet during reset and for one cycle after it.
    always_comb begin
        imem_req_valid = (state == FETCH_IDLE) && (32'(count) < BUF_DEPTH)
                         && !rst && !rst_q;
        push           = (state == FETCH_WAIT) && imem_resp_valid && !redirect;
    end

    assign accept = imem_req_valid && imem_req_ready;

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            if (redirect) begin
                pc <= redirect_pc & ~32'h3;
            end else if (accept) begin
                pc <= pc + 32'd4;
            end
            if (accept) begin
                req_pc <= pc;
            end
        end
    end

    assign imem_req_addr = pc;

    fetch_buf u_fetch_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (push),
        .push_entry ('{pc: req_pc, inst: imem_resp_data}),
        .pop        (pop),
        .count      (count),
        .head       (head)
    );

    assign inst_valid = (count != 2'd0) && !rst;
    assign pop        = inst_valid && inst_ready;
    assign inst       = rst ? '0 : head.inst;
    assign inst_pc    = rst ? '0 : head.pc;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: directed scenarios plus a randomized run against a
// transaction-level model (queue of {pc, inst}, outstanding/discard flags).
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    always #5 clk = ~clk;

    ifu dut (
        .clk             (clk),
        .rst             (rst),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    int checks = 0;
    int errors = 0;

    // stimulus controls
    logic        d_rst = 1'b1;
    logic        d_redirect = 1'b0;
    logic [31:0] d_rpc = '0;
    logic        d_ready = 1'b0;
    logic        d_iready = 1'b0;
    int unsigned d_lat = 1;

    // reference model
    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc = '0;
    logic [31:0] m_req_pc = '0;
    bit          m_out = 0;
    bit          m_drop = 0;
    bit          m_boot = 0;

    // memory model: one pending request, answered after d_lat cycles
    bit          mem_busy = 0;
    logic [31:0] mem_addr = '0;
    int unsigned mem_cnt = 0;

    logic        exp_req_valid;
    logic [31:0] exp_addr;
    logic        exp_inst_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_inst_pc;
    logic        cur_resp;

    logic [31:0] acc_q[$];
    logic [31:0] del_pc_q[$];
    logic [31:0] del_data_q[$];
    int          del_cyc_q[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic setup();
        rst            = d_rst;
        redirect       = d_redirect;
        redirect_pc    = d_rpc;
        imem_req_ready = d_ready;
        inst_ready     = d_iready;
        cur_resp       = mem_busy && (mem_cnt == 0);
        imem_resp_valid = cur_resp;
        imem_resp_data  = cur_resp ? mem_data(mem_addr) : $urandom;
        exp_req_valid  = !d_rst && !m_boot && !m_out && (mq.size() < 2);
        exp_addr       = m_pc;
        exp_inst_valid = !d_rst && (mq.size() != 0);
        if (exp_inst_valid) begin
            exp_inst    = mq[0].data;
            exp_inst_pc = mq[0].pc;
        end else begin
            exp_inst    = '0;
            exp_inst_pc = '0;
        end
        #1;
    endtask

    task automatic advance();
        bit          acc;
        bit          popped;
        logic [31:0] addr;
        acc    = exp_req_valid && d_ready;
        popped = exp_inst_valid && d_iready;
        addr   = m_pc;
        @(posedge clk);
        #1;
        if (mem_busy) begin
            if (cur_resp) mem_busy = 0;
            else mem_cnt--;
        end
        if (d_rst && mem_busy) mem_cnt = 0;
        if (acc) begin
            mem_busy = 1;
            mem_addr = addr;
            mem_cnt  = d_lat - 1;
        end
        if (d_rst) begin
            m_pc = 32'h0000_3000;
            mq.delete();
            m_out  = 0;
            m_boot = 1;
        end else begin
            m_boot = 0;
            if (d_redirect) begin
                mq.delete();
                if (m_out && cur_resp) m_out = 0;
                else if (m_out) m_drop = 1;
                if (acc) begin
                    m_out  = 1;
                    m_drop = 1;
                end
                m_pc = {d_rpc[31:2], 2'b00};
            end else begin
                if (popped) void'(mq.pop_front());
                if (m_out && cur_resp) begin
                    if (!m_drop) mq.push_back('{pc: m_req_pc, data: imem_resp_data});
                    m_out = 0;
                end
                if (acc) begin
                    m_req_pc = addr;
                    m_out    = 1;
                    m_drop   = 0;
                    m_pc     = addr + 32'd4;
                end
            end
        end
    endtask

    task automatic do_reset();
        d_rst = 1'b1;
        d_redirect = 1'b0;
        d_lat = 1;
        repeat (2) begin
            setup();
            advance();
        end
        d_rst = 1'b0;
    endtask

    task automatic run_collect(input int n);
        acc_q.delete();
        del_pc_q.delete();
        del_data_q.delete();
        del_cyc_q.delete();
        for (int c = 0; c < n; c++) begin
            setup();
            if (imem_req_valid && imem_req_ready) acc_q.push_back(imem_req_addr);
            if (inst_valid && inst_ready) begin
                del_pc_q.push_back(inst_pc);
                del_data_q.push_back(inst);
                del_cyc_q.push_back(c);
            end
            advance();
        end
    endtask

    task automatic test_reset();
        d_rst = 1'b1; d_redirect = 1'b0; d_ready = 1'b1; d_iready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            setup();
            checks++;
            if ({imem_req_valid, inst_valid, inst, inst_pc} !== 66'd0) begin
                errors++;
                $display("FAIL reset_outputs: got rv=%b iv=%b inst=%h pc=%h want all zero",
                         imem_req_valid, inst_valid, inst, inst_pc);
            end
            advance();
        end
        d_rst = 1'b0;
        setup();
        checks++;
        if ({imem_req_valid, inst_valid, inst, inst_pc, imem_req_addr} !== {66'd0, 32'h0000_3000}) begin
            errors++;
            $display("FAIL post_reset: got rv=%b iv=%b inst=%h pc=%h addr=%h want 0 0 0 0 00003000",
                     imem_req_valid, inst_valid, inst, inst_pc, imem_req_addr);
        end
        advance();
        setup();
        checks++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0000_3000}) begin
            errors++;
            $display("FAIL first_request: got rv=%b addr=%h want 1 00003000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_steady();
        logic [31:0] a;
        d_ready = 1'b1; d_iready = 1'b1; d_lat = 1;
        run_collect(20);
        checks++;
        if (acc_q.size() < 3 || del_pc_q.size() < 3) begin
            errors++;
            $display("FAIL steady_count: got %0d requests %0d deliveries want >=3 each", acc_q.size(), del_pc_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                a = 32'h0000_3000 + 32'(4 * i);
                checks++;
                if ({acc_q[i], del_pc_q[i], del_data_q[i]} !== {a, a, mem_data(a)}) begin
                    errors++;
                    $display("FAIL steady_seq[%0d]: got req=%h pc=%h inst=%h want %h %h %h",
                             i, acc_q[i], del_pc_q[i], del_data_q[i], a, a, mem_data(a));
                end
                checks++;
                if (del_cyc_q[i] !== 2 * (i + 1)) begin
                    errors++;
                    $display("FAIL steady_cadence[%0d]: got cycle %0d want %0d", i, del_cyc_q[i], 2 * (i + 1));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        d_ready = 1'b1; d_iready = 1'b0; d_lat = 1;
        for (int c = 0; c < 12; c++) begin
            setup();
            if (c >= 3) begin
                checks++;
                if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h0000_3000, mem_data(32'h0000_3000)}) begin
                    errors++;
                    $display("FAIL bp_head c%0d: got iv=%b pc=%h inst=%h want 1 00003000 %h",
                             c, inst_valid, inst_pc, inst, mem_data(32'h0000_3000));
                end
            end
            if (c >= 5) begin
                checks++;
                if (imem_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_req_held c%0d: got rv=%b want 0", c, imem_req_valid);
                end
            end
            advance();
        end
        d_iready = 1'b1;
        setup();
        advance();
        d_iready = 1'b0;
        setup();
        checks++;
        if ({inst_valid, inst_pc, imem_req_valid, imem_req_addr} !== {1'b1, 32'h0000_3004, 1'b1, 32'h0000_3008}) begin
            errors++;
            $display("FAIL bp_after_pop: got iv=%b pc=%h rv=%b addr=%h want 1 00003004 1 00003008",
                     inst_valid, inst_pc, imem_req_valid, imem_req_addr);
        end
        advance();
    endtask

    task automatic test_redirect_wait();
        bit found = 0;
        int n3008 = 0;
        do_reset();
        d_ready = 1'b1; d_iready = 1'b1; d_lat = 1;
        for (int c = 0; c < 20 && !found; c++) begin
            setup();
            if (imem_req_valid && imem_req_addr == 32'h0000_3008) begin
                d_lat = 4;
                found = 1;
            end
            advance();
            d_lat = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rw_reach_3008: got no request to 00003008 within 20 cycles want one");
        end
        d_redirect = 1'b1; d_rpc = 32'h0000_4002;
        setup();
        advance();
        d_redirect = 1'b0;
        setup();
        checks++;
        if ({inst_valid, imem_req_valid} !== 2'b00) begin
            errors++;
            $display("FAIL rw_flushed: got iv=%b rv=%b want 0 0", inst_valid, imem_req_valid);
        end
        run_collect(20);
        foreach (del_pc_q[i]) if (del_pc_q[i] == 32'h0000_3008) n3008++;
        checks++;
        if (n3008 != 0) begin
            errors++;
            $display("FAIL rw_dropped: got %0d deliveries of 00003008 want 0", n3008);
        end
        checks++;
        if (acc_q.size() == 0 || del_pc_q.size() == 0 ||
            {acc_q[0], del_pc_q[0], del_data_q[0]} !== {32'h0000_4000, 32'h0000_4000, mem_data(32'h0000_4000)}) begin
            errors++;
            $display("FAIL rw_target: got %0d req %0d del (first req=%h pc=%h) want 00004000",
                     acc_q.size(), del_pc_q.size(),
                     (acc_q.size() != 0) ? acc_q[0] : 32'hx, (del_pc_q.size() != 0) ? del_pc_q[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_coincident();
        bit found = 0;
        // redirect lands in the same cycle as the WAIT response
        do_reset();
        d_ready = 1'b1; d_iready = 1'b1; d_lat = 1;
        for (int c = 0; c < 10 && !found; c++) begin
            setup();
            found = imem_req_valid;
            advance();
        end
        d_redirect = 1'b1; d_rpc = 32'h0000_5000;
        setup();
        advance();
        d_redirect = 1'b0;
        setup();
        checks++;
        if ({inst_valid, imem_req_valid, imem_req_addr} !== {1'b0, 1'b1, 32'h0000_5000}) begin
            errors++;
            $display("FAIL rc_wait_resp: got iv=%b rv=%b addr=%h want 0 1 00005000",
                     inst_valid, imem_req_valid, imem_req_addr);
        end
        run_collect(10);
        checks++;
        if (del_pc_q.size() == 0 || del_pc_q[0] !== 32'h0000_5000) begin
            errors++;
            $display("FAIL rc_wait_target: got %0d deliveries first=%h want 00005000",
                     del_pc_q.size(), (del_pc_q.size() != 0) ? del_pc_q[0] : 32'hx);
        end
        // redirect lands in the same cycle as a request acceptance
        do_reset();
        d_lat = 2;
        found = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            setup();
            if (imem_req_valid) begin
                found = 1;
                d_redirect = 1'b1; d_rpc = 32'h0000_6000;
                setup();
            end
            advance();
        end
        d_redirect = 1'b0;
        d_lat = 1;
        setup();
        checks++;
        if ({imem_req_valid, inst_valid, imem_req_addr} !== {2'b00, 32'h0000_6000}) begin
            errors++;
            $display("FAIL rc_idle_drop: got rv=%b iv=%b addr=%h want 0 0 00006000",
                     imem_req_valid, inst_valid, imem_req_addr);
        end
        run_collect(10);
        checks++;
        if (acc_q.size() == 0 || del_pc_q.size() == 0 ||
            {acc_q[0], del_pc_q[0], del_data_q[0]} !== {32'h0000_6000, 32'h0000_6000, mem_data(32'h0000_6000)}) begin
            errors++;
            $display("FAIL rc_idle_target: got %0d req %0d del want first 00006000", acc_q.size(), del_pc_q.size());
        end
    endtask

    task automatic test_wrap();
        do_reset();
        d_ready = 1'b0; d_iready = 1'b1;
        d_redirect = 1'b1; d_rpc = 32'hFFFF_FFFC;
        setup();
        advance();
        d_redirect = 1'b0; d_ready = 1'b1; d_lat = 1;
        run_collect(10);
        checks++;
        if (acc_q.size() < 2 || del_pc_q.size() < 2 ||
            {acc_q[0], acc_q[1], del_pc_q[0], del_pc_q[1], del_data_q[1]} !==
            {32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 32'h0, mem_data(32'h0)}) begin
            errors++;
            $display("FAIL wrap: got %0d req %0d del (req0=%h req1=%h) want FFFFFFFC then 00000000",
                     acc_q.size(), del_pc_q.size(),
                     (acc_q.size() > 0) ? acc_q[0] : 32'hx, (acc_q.size() > 1) ? acc_q[1] : 32'hx);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        do_reset();
        d_ready = 1'b1; d_iready = 1'b0; d_lat = 1;
        for (int c = 0; c < 10 && !found; c++) begin
            setup();
            if (imem_req_valid && imem_req_addr == 32'h0000_3004) begin
                d_lat = 6;
                found = 1;
            end
            advance();
        end
        setup();
        checks++;
        if ({inst_valid, inst_pc, imem_req_valid} !== {1'b1, 32'h0000_3000, 1'b0}) begin
            errors++;
            $display("FAIL rm_pre: got iv=%b pc=%h rv=%b want 1 00003000 0", inst_valid, inst_pc, imem_req_valid);
        end
        advance();
        d_rst = 1'b1;
        setup();
        checks++;
        if ({imem_req_valid, inst_valid, inst, inst_pc} !== 66'd0) begin
            errors++;
            $display("FAIL rm_during: got rv=%b iv=%b inst=%h pc=%h want all zero",
                     imem_req_valid, inst_valid, inst, inst_pc);
        end
        advance();
        d_rst = 1'b0;
        setup();
        checks++;
        if ({imem_req_valid, inst_valid, imem_req_addr} !== {2'b00, 32'h0000_3000}) begin
            errors++;
            $display("FAIL rm_after: got rv=%b iv=%b addr=%h want 0 0 00003000", imem_req_valid, inst_valid, imem_req_addr);
        end
        advance();
        d_iready = 1'b1; d_lat = 1;
        run_collect(10);
        checks++;
        if (acc_q.size() == 0 || del_pc_q.size() == 0 ||
            {acc_q[0], del_pc_q[0], del_data_q[0]} !== {32'h0000_3000, 32'h0000_3000, mem_data(32'h0000_3000)}) begin
            errors++;
            $display("FAIL rm_resume: got %0d req %0d del first pc=%h want 00003000",
                     acc_q.size(), del_pc_q.size(), (del_pc_q.size() != 0) ? del_pc_q[0] : 32'hx);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            d_rst      = ($urandom_range(0, 99) == 0);
            d_redirect = ($urandom_range(0, 9) == 0);
            d_rpc      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            d_ready    = 1'($urandom_range(0, 1));
            d_iready   = ($urandom_range(0, 3) != 0);
            d_lat      = $urandom_range(1, 3);
            setup();
            checks++;
            if ({imem_req_valid, imem_req_valid ? imem_req_addr : 32'h0} !==
                {exp_req_valid, exp_req_valid ? exp_addr : 32'h0}) begin
                errors++;
                $display("FAIL rand_req c%0d: got rv=%b addr=%h want rv=%b addr=%h",
                         c, imem_req_valid, imem_req_addr, exp_req_valid, exp_addr);
            end
            checks++;
            if ({inst_valid, inst, inst_pc} !== {exp_inst_valid, exp_inst, exp_inst_pc}) begin
                errors++;
                $display("FAIL rand_inst c%0d: got iv=%b inst=%h pc=%h want iv=%b inst=%h pc=%h",
                         c, inst_valid, inst, inst_pc, exp_inst_valid, exp_inst, exp_inst_pc);
            end
            advance();
        end
        d_rst = 1'b0;
        d_redirect = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_steady();
        test_backpressure();
        test_redirect_wait();
        test_redirect_coincident();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
